// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: source codes matching the
// write-back mux select pin, and the default datapath widths.
package wb_pkg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    typedef enum logic [2:0] {
        SRC_NONE = 3'b000,
        SRC_ALU  = 3'b001,
        SRC_MEM  = 3'b010,
        SRC_MDU  = 3'b011
    } src_e;

    localparam int IDX_ALU = 0;
    localparam int IDX_MEM = 1;
    localparam int IDX_MDU = 2;

    function automatic src_e idx_to_src(input int idx);
        case (idx)
            IDX_ALU: return SRC_ALU;
            IDX_MEM: return SRC_MEM;
            IDX_MDU: return SRC_MDU;
            default: return SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_arb3.sv
// Three-way round-robin picker: bit 0 ALU, bit 1 MEM, bit 2 MDU.
// The search begins at the source after last_q; last_d is the pointer update.
module rr_arb3
    import wb_pkg::*;
(
    input  logic [2:0] elig,
    input  src_e       last_q,
    output logic [2:0] gnt,
    output src_e       last_d
);

    logic [1:0] base_idx;

    always_comb begin
        case (last_q)
            SRC_ALU: base_idx = 2'd0;
            SRC_MEM: base_idx = 2'd1;
            default: base_idx = 2'd2;
        endcase
    end

    always_comb begin
        gnt    = '0;
        last_d = last_q;
        for (int i = 1; i <= 3; i++) begin
            int idx;
            idx = (int'(base_idx) + i) % 3;
            if (gnt == 3'b000 && elig[idx]) begin
                gnt[idx] = 1'b1;
                last_d   = idx_to_src(idx);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: shares one write port between ALU, MEM
// and MDU with round-robin selection and a WAW guard on the ALU.
module wb_arbiter #(
    parameter int XLEN = wb_pkg::XLEN,
    parameter int RW   = wb_pkg::RW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [RW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [RW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic            mdu_valid,
    input  logic [RW-1:0]   mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            mdu_ready,
    output logic            rf_we,
    output logic [RW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [2:0]      wb_sel,
    output logic            stall
);
    import wb_pkg::*;

    logic            alu_blk;
    logic [2:0]      valid_vec;
    logic [2:0]      elig;
    logic [2:0]      gnt;
    src_e            last_q, last_d;

    logic [RW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    src_e            win_src;

    logic            rf_we_q, rf_we_d;
    logic [RW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    src_e            wb_sel_q, wb_sel_d;

    // An older long-latency result to the same nonzero rd must land first.
    always_comb begin
        alu_blk = (alu_rd != '0) &&
                  ((mem_valid && (alu_rd == mem_rd)) ||
                   (mdu_valid && (alu_rd == mdu_rd)));
    end

    always_comb begin
        valid_vec = {mdu_valid, mem_valid, alu_valid};
        elig      = rst ? 3'b000 : {mdu_valid, mem_valid, alu_valid && !alu_blk};
    end

    rr_arb3 u_rr_arb3 (
        .elig   (elig),
        .last_q (last_q),
        .gnt    (gnt),
        .last_d (last_d)
    );

    always_comb begin
        alu_ready = gnt[IDX_ALU];
        mem_ready = gnt[IDX_MEM];
        mdu_ready = gnt[IDX_MDU];
        stall     = !rst && ((valid_vec & ~gnt) != 3'b000);
    end

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        win_src  = SRC_NONE;
        if (gnt[IDX_ALU]) begin
            win_rd   = alu_rd;
            win_data = alu_data;
            win_src  = SRC_ALU;
        end else if (gnt[IDX_MEM]) begin
            win_rd   = mem_rd;
            win_data = mem_data;
            win_src  = SRC_MEM;
        end else if (gnt[IDX_MDU]) begin
            win_rd   = mdu_rd;
            win_data = mdu_data;
            win_src  = SRC_MDU;
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        wb_sel_d   = SRC_NONE;
        if (win_src != SRC_NONE && win_rd != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = win_rd;
            rf_wdata_d = win_data;
            wb_sel_d   = win_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= SRC_MDU;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_sel_q   <= SRC_NONE;
        end else begin
            last_q     <= last_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_sel_q   <= wb_sel_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign wb_sel   = wb_sel_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a cycle-by-cycle vector table plus a
// hand-written back-to-back ALU sequence.
module tb_wb_arbiter;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, mem_valid, mdu_valid;
    logic [RW-1:0]   alu_rd, mem_rd, mdu_rd;
    logic [XLEN-1:0] alu_data, mem_data, mdu_data;
    logic            alu_ready, mem_ready, mdu_ready;
    logic            rf_we;
    logic [RW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [2:0]      wb_sel;
    logic            stall;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .RW(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .mdu_valid (mdu_valid),
        .mdu_rd    (mdu_rd),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .wb_sel    (wb_sel),
        .stall     (stall)
    );

    typedef struct {
        logic            rst;
        logic            av;
        logic [RW-1:0]   ar;
        logic [XLEN-1:0] ad;
        logic            mv;
        logic [RW-1:0]   mr;
        logic [XLEN-1:0] md;
        logic            dv;
        logic [RW-1:0]   dr;
        logic [XLEN-1:0] dd;
        logic [2:0]      rdy;   // {mdu, mem, alu}
        logic            stl;
        logic            we;
        logic [RW-1:0]   wa;
        logic [XLEN-1:0] wd;
        logic [2:0]      sel;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [vec %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic add(input logic r,
                       input logic av, input int ar, input int ad,
                       input logic mv, input int mr, input int md,
                       input logic dv, input int dr, input int dd,
                       input logic [2:0] rdy, input logic stl,
                       input logic we, input int wa, input int wd, input logic [2:0] sel);
        vec_t v;
        v.rst = r;
        v.av = av; v.ar = RW'(ar); v.ad = XLEN'(ad);
        v.mv = mv; v.mr = RW'(mr); v.md = XLEN'(md);
        v.dv = dv; v.dr = RW'(dr); v.dd = XLEN'(dd);
        v.rdy = rdy; v.stl = stl;
        v.we = we; v.wa = RW'(wa); v.wd = XLEN'(wd); v.sel = sel;
        tbl.push_back(v);
    endtask

    task automatic apply_and_check(input vec_t v, input int idx);
        rst       = v.rst;
        alu_valid = v.av; alu_rd = v.ar; alu_data = v.ad;
        mem_valid = v.mv; mem_rd = v.mr; mem_data = v.md;
        mdu_valid = v.dv; mdu_rd = v.dr; mdu_data = v.dd;
        #1;
        chk("ready", idx, {29'd0, mdu_ready, mem_ready, alu_ready}, {29'd0, v.rdy});
        chk("stall", idx, {31'd0, stall}, {31'd0, v.stl});
        @(posedge clk);
        #1;
        chk("rf_we",    idx, {31'd0, rf_we}, {31'd0, v.we});
        chk("rf_waddr", idx, {27'd0, rf_waddr}, {27'd0, v.wa});
        chk("rf_wdata", idx, rf_wdata, v.wd);
        chk("wb_sel",   idx, {29'd0, wb_sel}, {29'd0, v.sel});
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; mem_valid = 0; mdu_valid = 0;
        alu_rd = 0; mem_rd = 0; mdu_rd = 0;
        alu_data = 0; mem_data = 0; mdu_data = 0;

        //   rst  alu           mem           mdu             rdy     stl  we wa  wd       sel
        add(1, 0, 0, 0,      0, 0, 0,      0, 0, 0,        3'b000, 0,   0, 0,  0,       3'b000);
        add(1, 1, 5, 'h1234, 0, 0, 0,      0, 0, 0,        3'b000, 0,   0, 0,  0,       3'b000);
        add(0, 1, 5, 'h1234, 0, 0, 0,      0, 0, 0,        3'b001, 0,   1, 5,  'h1234,  3'b001);
        add(1, 0, 0, 0,      0, 0, 0,      0, 0, 0,        3'b000, 0,   0, 0,  0,       3'b000);
        // all three valid right after reset: ALU, MEM, MDU
        add(0, 1, 1, 'hA1,   1, 2, 'hA2,   1, 3, 'hA3,     3'b001, 1,   1, 1,  'hA1,    3'b001);
        add(0, 0, 0, 0,      1, 2, 'hA2,   1, 3, 'hA3,     3'b010, 1,   1, 2,  'hA2,    3'b010);
        add(0, 0, 0, 0,      0, 0, 0,      1, 3, 'hA3,     3'b100, 0,   1, 3,  'hA3,    3'b011);
        add(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,        3'b000, 0,   0, 3,  'hA3,    3'b000);
        // WAW on r7: MEM first, then ALU
        add(0, 1, 7, 'hB2,   1, 7, 'hB1,   0, 0, 0,        3'b010, 1,   1, 7,  'hB1,    3'b010);
        add(0, 1, 7, 'hB2,   0, 0, 0,      0, 0, 0,        3'b001, 0,   1, 7,  'hB2,    3'b001);
        // MDU write to x0 is accepted and dropped
        add(0, 0, 0, 0,      0, 0, 0,      1, 0, 'hFFFF,   3'b100, 0,   0, 7,  'hB2,    3'b000);
        // reset right after an ALU grant
        add(0, 1, 9, 'hC1,   0, 0, 0,      0, 0, 0,        3'b001, 0,   1, 9,  'hC1,    3'b001);
        add(1, 0, 0, 0,      1, 4, 'hD1,   0, 0, 0,        3'b000, 0,   0, 0,  0,       3'b000);
        add(0, 1, 10, 'hC2,  1, 4, 'hD1,   0, 0, 0,        3'b001, 1,   1, 10, 'hC2,    3'b001);
        add(0, 0, 0, 0,      1, 4, 'hD1,   0, 0, 0,        3'b010, 0,   1, 4,  'hD1,    3'b010);
        // x0 on both ALU and MEM: no guard, ALU first after reset
        add(1, 0, 0, 0,      0, 0, 0,      0, 0, 0,        3'b000, 0,   0, 0,  0,       3'b000);
        add(0, 1, 0, 'hE1,   1, 0, 'hE2,   0, 0, 0,        3'b001, 1,   0, 0,  0,       3'b000);
        add(0, 0, 0, 0,      1, 0, 'hE2,   0, 0, 0,        3'b010, 0,   0, 0,  0,       3'b000);
        // pointer at MEM: ring wraps MDU, ALU, MEM
        add(0, 1, 1, 'hF1,   1, 2, 'hF2,   1, 3, 'hF3,     3'b100, 1,   1, 3,  'hF3,    3'b011);
        add(0, 1, 1, 'hF1,   1, 2, 'hF2,   0, 0, 0,        3'b001, 1,   1, 1,  'hF1,    3'b001);
        add(0, 0, 0, 0,      1, 2, 'hF2,   0, 0, 0,        3'b010, 0,   1, 2,  'hF2,    3'b010);
        // WAW against MDU while ALU would otherwise be next
        add(0, 0, 0, 0,      0, 0, 0,      1, 11, 'h40,    3'b100, 0,   1, 11, 'h40,    3'b011);
        add(0, 1, 6, 'h61,   0, 0, 0,      1, 6, 'h62,     3'b100, 1,   1, 6,  'h62,    3'b011);
        add(0, 1, 6, 'h61,   0, 0, 0,      0, 0, 0,        3'b001, 0,   1, 6,  'h61,    3'b001);
        // matching rd on an idle MEM channel does not block
        add(0, 1, 2, 'h71,   0, 2, 'h72,   0, 0, 0,        3'b001, 0,   1, 2,  'h71,    3'b001);

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply_and_check(tbl[i], i);

        // A continuously valid ALU is granted every cycle.
        for (int k = 0; k < 4; k++) begin
            rst = 1'b0;
            mem_valid = 1'b0; mdu_valid = 1'b0;
            alu_valid = 1'b1; alu_rd = RW'(12); alu_data = 32'h100 + k;
            #1;
            chk("b2b_alu_ready", 100 + k, {31'd0, alu_ready}, 32'd1);
            chk("b2b_stall",     100 + k, {31'd0, stall}, 32'd0);
            @(posedge clk);
            #1;
            chk("b2b_rf_we",    100 + k, {31'd0, rf_we}, 32'd1);
            chk("b2b_rf_waddr", 100 + k, {27'd0, rf_waddr}, 32'd12);
            chk("b2b_rf_wdata", 100 + k, rf_wdata, 32'h100 + k);
            chk("b2b_wb_sel",   100 + k, {29'd0, wb_sel}, 32'd1);
        end
        alu_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Register-file write-port arbiter for the write-back stage. It shares the single register-file write port between three result producers: the ALU (single-cycle), the load-return path of the data-memory interface (MEM) and the multiply/divide unit (MDU). Sources are selected round-robin with a write-after-write guard. The winner's write is registered for one cycle toward the register file. A source code for the existing write-back multiplexer select pin and a front-end stall are also produced.

## Interface
Parameters:
- XLEN, 32, data width
- RW, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result available
- alu_rd  in  RW  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- mem_valid, mem_rd, mem_data, mem_ready  in/in/in/out  1/RW/XLEN/1  load-return channel, same semantics
- mdu_valid, mdu_rd, mdu_data, mdu_ready  in/in/in/out  1/RW/XLEN/1  MDU channel, same semantics
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  RW  write address (registered)
- rf_wdata  out  XLEN  write data (registered)
- wb_sel  out  3  source of the current rf write: 000 none, 001 ALU, 010 MEM, 011 MDU (registered)
- stall  out  1  some valid source was not granted this cycle (combinational)

## Operation
- Handshake: a transfer occurs when `x_valid && x_ready`. `x_ready` is combinational and is asserted for at most one source per cycle. A source holds `valid`, `rd` and `data` stable until it is accepted.
- Eligibility:
  - MEM and MDU are eligible whenever valid.
  - ALU is eligible only if valid and `alu_rd` equals neither `mem_rd` (when `mem_valid`) nor `mdu_rd` (when `mdu_valid`), for nonzero rd. This is the WAW guard: an older long-latency result must land first.
  - An x0 match never blocks the ALU.
- Arbitration: a round-robin pointer `last` ∈ {ALU, MEM, MDU}. The search order starts at the source after `last` in the ring ALU→MEM→MDU→ALU. The first eligible source wins. `last` updates to the winner only on a grant and holds otherwise.
- Write: on a grant, the next cycle drives `rf_we=1`, `rf_waddr=rd`, `rf_wdata=data` and `wb_sel` set to the source code.
- Grant with `rd==0`: the request is still accepted (ready=1). The next cycle has `rf_we=0` and `wb_sel=000`; the data is discarded.
- No grant: the next cycle has `rf_we=0`, `wb_sel=000`. `rf_waddr` and `rf_wdata` hold their previous values.
- `stall = (alu_valid|mem_valid|mdu_valid) && !(any grant that covers every valid)`. That is, stall is 1 whenever at least one valid source has ready=0 this cycle.

## Timing
- Grant to rf write: 1 cycle latency; back-to-back grants are allowed every cycle.
- Reset values (applied on the rising clock edge while `rst=1`):
  - `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `wb_sel=000`
  - `last=MDU`, so ALU has first priority after reset
  - all readys are 0 while `rst=1`; stall is 0 while `rst=1`
- Reset mid-operation: a registered write pending when reset is sampled is dropped (`rf_we=0` on the next cycle). Requests sampled during reset are not accepted.
- All three valid, no WAW conflict: three consecutive grants in ring order, one per cycle, provided the sources keep their valids up.
- A single continuously valid source is granted every cycle.

## Structure
- Shared package `wb_pkg`:
  - source enum SRC_NONE=3'b000, SRC_ALU=3'b001, SRC_MEM=3'b010, SRC_MDU=3'b011, matching the write-back mux select encoding
  - XLEN and RW constants
- One natural sub-module: `rr_arb3`. It takes a 3-bit eligible vector and the `last` pointer and returns a one-hot grant plus the pointer register update. The WAW guard and output register stay in `wb_arbiter`.

## Test plan
- Reset, then only `alu_valid` with rd=5, data=0x1234 → alu_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_sel=001.
- All three valid with rd=1/2/3 immediately after reset, held → grants in the order ALU, MEM, MDU over 3 cycles; stall=1 for the first 2 cycles and 0 on the third; rf writes follow 1 cycle later.
- `mem_valid` rd=7 and `alu_valid` rd=7 together → ALU is blocked, MEM is granted; ALU is granted the next cycle; the rf sees writes to 7 in MEM-then-ALU order.
- `mdu_valid` with rd=0, data=0xFFFF → mdu_ready=1; next cycle rf_we=0, wb_sel=000.
- `rst` asserted the cycle after an ALU grant → rf_we=0 the following cycle; after reset release, ALU wins over simultaneous MEM.
- MEM rd=0 and ALU rd=0 both valid → no WAW block; round-robin decides (ALU first after reset), and each is accepted with rf_we=0.
